// File: rtl/ahb_sub_mem.sv
// ahb_sub_mem: AHB-Lite subordinate wrapping a word-addressed on-chip RAM.
//   Programmable wait states, byte-strobed writes, two-cycle ERROR responses
//   for out-of-range / oversized / misaligned accesses, and a one-cycle
//   burst_err pulse when HBURST changes on a SEQ beat.
// Ports:
//   HCLK, HRESET (async, active-high)
//   HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK : address phase
//   HWDATA, HWSTRB                                                  : write data phase
//   HREADY                                                          : bus-level ready
//   HRDATA, HREADYOUT, HRESP                                        : response
//   burst_err                                                       : HBURST change flag
module ahb_sub_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSELx,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic                    HMASTLOCK,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic [DATA_WIDTH/8-1:0] HWSTRB,
  input  logic                    HREADY,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic                    burst_err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int BS = $clog2(NB);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH * NB);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  // Lanes covered by a transfer of 2^size bytes starting at byte offset off.
  function automatic logic [NB-1:0] lane_mask(input logic [BS-1:0] off, input logic [2:0] size);
    logic [NB-1:0] m;
    logic [BS-1:0] bl;
    for (int b = 0; b < NB; b++) begin
      bl   = BS'(b);
      m[b] = ((bl >> size) == (off >> size));
    end
    return m;
  endfunction

  function automatic logic misaligned(input logic [7:0] a, input logic [2:0] size);
    return |(a & ~(8'hFF << size));
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[BS +: IW];
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_t                state;
  logic [15:0]           wcnt;
  logic                  hreadyout_q, hresp_q, burst_err_q;
  logic [DATA_WIDTH-1:0] hrdata_q;
  logic [2:0]            hburst_q;

  logic [ADDR_WIDTH-1:0] haddr_p1;
  logic                  hwrite_p1;
  logic [2:0]            hsize_p1;
  logic                  vld_p1;

  logic                  accept, illegal;
  logic [NB-1:0]         wmask;
  logic [IW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  logic unused_sig;
  assign unused_sig = ^{HPROT, HMASTLOCK};

  assign accept  = HSELx & HREADY & HTRANS[1];
  assign illegal = ({1'b0, HADDR} >= LIMIT) || (HSIZE > 3'(BS)) || misaligned(HADDR[7:0], HSIZE);
  assign wmask   = HWSTRB & lane_mask(haddr_p1[BS-1:0], hsize_p1);

  // Read word: current address phase when zero-wait, captured address once
  // the wait states run out. A write committing on the same edge is merged in.
  always_comb begin
    rd_idx  = (state == S_WAIT) ? word_idx(haddr_p1) : word_idx(HADDR);
    rd_word = mem[rd_idx];
    if (vld_p1 && hwrite_p1 && (word_idx(haddr_p1) == rd_idx)) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask[b]) rd_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  // ---- p0 -> p1: address phase capture ----
  always_ff @(posedge HCLK) begin
    if (accept) begin
      haddr_p1  <= HADDR;
      hwrite_p1 <= HWRITE;
      hsize_p1  <= HSIZE;
    end
  end

  // ---- p1: data phase commit (edge ending the final data-phase cycle) ----
  always_ff @(posedge HCLK) begin
    if (vld_p1 && hwrite_p1) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask[b]) mem[word_idx(haddr_p1)][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state       <= S_IDLE;
      wcnt        <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      burst_err_q <= 1'b0;
      hburst_q    <= '0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1      <= 1'b0;
      burst_err_q <= 1'b0;
      if (accept) begin
        if (!HTRANS[0])              hburst_q    <= HBURST;
        else if (HBURST != hburst_q) burst_err_q <= 1'b1;
      end
      case (state)
        S_IDLE, S_ERR2: begin
          state       <= S_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
          if (accept) begin
            if (illegal) begin
              state       <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state       <= S_WAIT;
              hreadyout_q <= 1'b0;
              wcnt        <= 16'(WAIT_STATES - 1);
            end else begin
              vld_p1 <= 1'b1;
              if (!HWRITE) hrdata_q <= rd_word;
            end
          end
        end
        S_WAIT: begin
          if (wcnt == 16'd0) begin
            state       <= S_IDLE;
            hreadyout_q <= 1'b1;
            vld_p1      <= 1'b1;
            if (!hwrite_p1) hrdata_q <= rd_word;
          end else begin
            wcnt <= wcnt - 16'd1;
          end
        end
        S_ERR1: begin
          state       <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign HRDATA    = hrdata_q;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign burst_err = burst_err_q;

endmodule

// File: tb/tb_ahb_sub_mem.sv
module tb_ahb_sub_mem;

  logic        HCLK, HRESET;
  logic        HSELx, HWRITE, HMASTLOCK, HREADY, HREADYOUT, HRESP, burst_err;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT, HWSTRB;

  logic        z_HSELx, z_HWRITE, z_HREADY, z_HREADYOUT, z_HRESP, z_burst_err;
  logic [31:0] z_HADDR, z_HWDATA, z_HRDATA;
  logic [1:0]  z_HTRANS;
  logic [2:0]  z_HSIZE;
  logic [3:0]  z_HWSTRB;

  int checks = 0;
  int errors = 0;

  assign HREADY   = HREADYOUT;
  assign z_HREADY = z_HREADYOUT;

  ahb_sub_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSELx(HSELx), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HWDATA(HWDATA), .HWSTRB(HWSTRB), .HREADY(HREADY), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .burst_err(burst_err)
  );

  ahb_sub_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) dut_z (
    .HCLK(HCLK), .HRESET(HRESET), .HSELx(z_HSELx), .HADDR(z_HADDR), .HTRANS(z_HTRANS),
    .HWRITE(z_HWRITE), .HSIZE(z_HSIZE), .HBURST(3'b000), .HPROT(4'h0), .HMASTLOCK(1'b0),
    .HWDATA(z_HWDATA), .HWSTRB(z_HWSTRB), .HREADY(z_HREADY), .HRDATA(z_HRDATA),
    .HREADYOUT(z_HREADYOUT), .HRESP(z_HRESP), .burst_err(z_burst_err)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transfer: address phase, then the data phase until HREADYOUT=1.
  // Returns during the final data-phase cycle so the next call pipelines.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [2:0] burst, input logic [1:0] trans,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rdata, output int waits,
                      output logic resp0, output logic resp1,
                      output logic be0, output logic be1);
    HSELx  = 1'b1;
    HADDR  = addr;
    HTRANS = trans;
    HWRITE = wr;
    HSIZE  = size;
    HBURST = burst;
    @(posedge HCLK); #1;
    HTRANS = 2'b00;
    HWDATA = wdata;
    HWSTRB = strb;
    resp0  = HRESP;
    be0    = burst_err;
    waits  = 0;
    while (HREADYOUT !== 1'b1 && waits < 16) begin
      waits++;
      @(posedge HCLK); #1;
    end
    resp1 = HRESP;
    be1   = burst_err;
    rdata = HRDATA;
  endtask

  logic [31:0] rd;
  int          wt;
  logic        r0, r1, b0, b1;

  initial begin
    HRESET = 1'b1; HSELx = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd2; HBURST = 3'd0; HPROT = 4'h0; HMASTLOCK = 1'b0; HWDATA = '0; HWSTRB = 4'h0;
    z_HSELx = 1'b0; z_HADDR = '0; z_HTRANS = 2'b00; z_HWRITE = 1'b0; z_HSIZE = 3'd2;
    z_HWDATA = '0; z_HWSTRB = 4'h0;
    repeat (2) @(posedge HCLK); #1;
    chk("rst_ready", HREADYOUT, 1'b1);
    chk("rst_resp", HRESP, 1'b0);
    chk("rst_rdata", HRDATA, 32'h0);
    chk("rst_berr", burst_err, 1'b0);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // word write / read with two wait states
    xfer(1'b1, 32'h10, 3'd2, 3'd0, 2'b10, 32'hDEADBEEF, 4'hF, rd, wt, r0, r1, b0, b1);
    chk("wr_waits", wt, 2);
    chk("wr_resp", r1, 1'b0);
    xfer(1'b0, 32'h10, 3'd2, 3'd0, 2'b10, 32'h0, 4'h0, rd, wt, r0, r1, b0, b1);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_waits", wt, 2);
    chk("rd_resp", {r0, r1}, 2'b00);

    // byte writes and lane window
    xfer(1'b1, 32'h10, 3'd2, 3'd0, 2'b10, 32'h11223344, 4'hF, rd, wt, r0, r1, b0, b1);
    xfer(1'b1, 32'h12, 3'd0, 3'd0, 2'b10, 32'h00AA0000, 4'b0100, rd, wt, r0, r1, b0, b1);
    xfer(1'b0, 32'h10, 3'd2, 3'd0, 2'b10, 32'h0, 4'h0, rd, wt, r0, r1, b0, b1);
    chk("byte_wr", rd, 32'h11AA3344);
    xfer(1'b1, 32'h12, 3'd0, 3'd0, 2'b10, 32'h55667788, 4'hF, rd, wt, r0, r1, b0, b1);
    xfer(1'b0, 32'h10, 3'd2, 3'd0, 2'b10, 32'h0, 4'h0, rd, wt, r0, r1, b0, b1);
    chk("lane_window", rd, 32'h11663344);

    // illegal accesses
    xfer(1'b0, 32'h1000, 3'd2, 3'd0, 2'b10, 32'h0, 4'h0, rd, wt, r0, r1, b0, b1);
    chk("oob_err1", r0, 1'b1);
    chk("oob_err2", r1, 1'b1);
    chk("oob_cycles", wt, 1);
    xfer(1'b0, 32'h2, 3'd2, 3'd0, 2'b10, 32'h0, 4'h0, rd, wt, r0, r1, b0, b1);
    chk("misal_resp", {r0, r1}, 2'b11);
    chk("misal_cycles", wt, 1);
    xfer(1'b1, 32'h12, 3'd2, 3'd0, 2'b10, 32'hFFFFFFFF, 4'hF, rd, wt, r0, r1, b0, b1);
    chk("misal_wr_resp", {r0, r1}, 2'b11);
    xfer(1'b1, 32'h10, 3'd3, 3'd0, 2'b10, 32'hFFFFFFFF, 4'hF, rd, wt, r0, r1, b0, b1);
    chk("size_err_resp", {r0, r1}, 2'b11);
    xfer(1'b0, 32'h10, 3'd2, 3'd0, 2'b10, 32'h0, 4'h0, rd, wt, r0, r1, b0, b1);
    chk("err_no_write", rd, 32'h11663344);

    // INCR4 burst
    xfer(1'b1, 32'h0, 3'd2, 3'b011, 2'b10, 32'd1, 4'hF, rd, wt, r0, r1, b0, b1);
    for (int i = 1; i < 4; i++) begin
      xfer(1'b1, 32'(4 * i), 3'd2, 3'b011, 2'b11, 32'(i + 1), 4'hF, rd, wt, r0, r1, b0, b1);
      chk("burst_no_err", b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 32'(4 * i), 3'd2, 3'b000, 2'b10, 32'h0, 4'h0, rd, wt, r0, r1, b0, b1);
      chk("burst_rdback", rd, 32'(i + 1));
    end
    xfer(1'b1, 32'h20, 3'd2, 3'b011, 2'b10, 32'd5, 4'hF, rd, wt, r0, r1, b0, b1);
    xfer(1'b1, 32'h24, 3'd2, 3'b001, 2'b11, 32'd6, 4'hF, rd, wt, r0, r1, b0, b1);
    chk("berr_pulse", b0, 1'b1);
    chk("berr_one_cycle", b1, 1'b0);
    chk("berr_resp", r1, 1'b0);
    xfer(1'b0, 32'h24, 3'd2, 3'b000, 2'b10, 32'h0, 4'h0, rd, wt, r0, r1, b0, b1);
    chk("berr_beat_data", rd, 32'd6);

    // IDLE and BUSY
    HADDR = 32'h10; HWRITE = 1'b1; HTRANS = 2'b00;
    @(posedge HCLK); #1;
    chk("idle_resp", {HREADYOUT, HRESP}, 2'b10);
    HTRANS = 2'b01;
    @(posedge HCLK); #1;
    chk("busy_resp", {HREADYOUT, HRESP}, 2'b10);
    xfer(1'b0, 32'h10, 3'd2, 3'd0, 2'b10, 32'h0, 4'h0, rd, wt, r0, r1, b0, b1);
    chk("idle_no_write", rd, 32'h11663344);

    // reset in the middle of a wait state
    HADDR = 32'h4; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HTRANS = 2'b00;
    chk("pre_rst_wait", HREADYOUT, 1'b0);
    HRESET = 1'b1;
    #1;
    chk("mid_rst_ready", HREADYOUT, 1'b1);
    chk("mid_rst_resp", HRESP, 1'b0);
    chk("mid_rst_rdata", HRDATA, 32'h0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    chk("post_rst_ready", HREADYOUT, 1'b1);
    xfer(1'b0, 32'h4, 3'd2, 3'd0, 2'b10, 32'h0, 4'h0, rd, wt, r0, r1, b0, b1);
    chk("post_rst_rd", rd, 32'd2);
    chk("post_rst_waits", wt, 2);

    // zero-wait instance: back-to-back write then read of the same word
    z_HSELx = 1'b1; z_HADDR = 32'h20; z_HTRANS = 2'b10; z_HWRITE = 1'b1; z_HSIZE = 3'd2;
    @(posedge HCLK); #1;
    chk("z_wr_ready", z_HREADYOUT, 1'b1);
    z_HWDATA = 32'hCAFEF00D; z_HWSTRB = 4'hF;
    z_HADDR = 32'h20; z_HTRANS = 2'b10; z_HWRITE = 1'b0; z_HSIZE = 3'd2;
    @(posedge HCLK); #1;
    chk("z_fwd_word", z_HRDATA, 32'hCAFEF00D);
    chk("z_rd_ready", {z_HREADYOUT, z_HRESP}, 2'b10);
    z_HADDR = 32'h21; z_HTRANS = 2'b10; z_HWRITE = 1'b1; z_HSIZE = 3'd0;
    @(posedge HCLK); #1;
    z_HWDATA = 32'h00005500; z_HWSTRB = 4'b0010;
    z_HADDR = 32'h20; z_HTRANS = 2'b10; z_HWRITE = 1'b0; z_HSIZE = 3'd2;
    @(posedge HCLK); #1;
    chk("z_fwd_byte", z_HRDATA, 32'hCAFE550D);
    z_HTRANS = 2'b00;
    @(posedge HCLK); #1;
    chk("z_rdata_hold", z_HRDATA, 32'hCAFE550D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_sub_mem.md
Name: ahb_sub_mem

Overview:
AHB-Lite subordinate wrapping a word-addressed on-chip RAM. It sits behind the bus decoder on the subordinate side of the AHB interface and is driven by HSELx. It supports programmable wait states, byte-strobed writes, and two-cycle ERROR responses for illegal accesses. It also flags HBURST changes inside a burst.

Parameters:
ADDR_WIDTH, 32, width of HADDR
DATA_WIDTH, 32, width of HWDATA/HRDATA; allowed values are 32 or 64
MEM_DEPTH, 1024, number of DATA_WIDTH-bit words; byte range is 0 to MEM_DEPTH*DATA_WIDTH/8-1
WAIT_STATES, 0, number of HREADYOUT=0 cycles inserted in every OKAY data phase

Ports:
HCLK  in  1  bus clock; all state updates on rising edge
HRESET  in  1  asynchronous, active-high reset
HSELx  in  1  subordinate select
HADDR  in  ADDR_WIDTH  byte address
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWRITE  in  1  1=write
HSIZE  in  3  transfer size, log2 bytes
HBURST  in  3  burst type
HPROT  in  4  accepted, no effect
HMASTLOCK  in  1  accepted, no effect
HWDATA  in  DATA_WIDTH  write data, valid in data phase
HWSTRB  in  DATA_WIDTH/8  byte-lane write strobes, data phase
HREADY  in  1  bus-level ready from the interconnect
HRDATA  out  DATA_WIDTH  read data
HREADYOUT  out  1  subordinate ready
HRESP  out  1  0=OKAY, 1=ERROR
burst_err  out  1  one-cycle pulse on an HBURST change mid-burst

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - HREADYOUT=1, HRESP=0, HRDATA=0, burst_err=0.
  - FSM returns to IDLE and any pending transfer is dropped.
  - RAM contents are not reset.
- Address phase is accepted on a rising edge when HSELx & HREADY & HTRANS[1]. The block registers HADDR, HWRITE, HSIZE and HBURST.
- IDLE or BUSY with HSELx & HREADY gives a zero-wait OKAY. No memory access.
- Legality check at acceptance. The transfer is illegal if any of the following holds:
  - word index HADDR/(DATA_WIDTH/8) >= MEM_DEPTH;
  - HSIZE > log2(DATA_WIDTH/8);
  - HADDR is not aligned to 2^HSIZE.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: on a legal accept, go to WAIT if WAIT_STATES>0; otherwise the next cycle is the final data-phase cycle (HREADYOUT=1, HRESP=0).
  - WAIT: hold HREADYOUT=0, HRESP=0 for exactly WAIT_STATES cycles, then drive one cycle of HREADYOUT=1.
  - On an illegal accept: ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE.
  - An ERROR transfer performs no memory write.
- New address phases are only sampled when HREADY=1, i.e. pipelined back-to-back transfers are supported.
- Write:
  - Committed at the edge ending the final data-phase cycle.
  - Byte lane b is written iff HWSTRB[b] is set and lane b lies inside the HSIZE/HADDR lane window.
- Read:
  - HRDATA holds the full addressed word during the final data-phase cycle; the block does not mask lanes.
  - Minimum latency: address phase at cycle N, data valid at cycle N+1 + WAIT_STATES.
  - A read immediately following a write to the same word returns the newly written bytes (forwarding required).
  - HRDATA keeps its last value outside read data phases.
- Burst check:
  - A NONSEQ accept stores HBURST.
  - A SEQ accept whose HBURST differs from the stored value pulses burst_err for one cycle, starting the cycle after the accept.
  - The transfer itself proceeds normally.
- HSELx deasserted: no accept. HREADYOUT still completes any in-flight data phase.

Test Plan:
1. Reset: assert HRESET mid-wait-state -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; FSM is IDLE.
2. Write 0xDEADBEEF to 0x10 (HSIZE=2, HWSTRB=4'hF), then read 0x10 -> HRDATA=0xDEADBEEF with HRESP=0. With WAIT_STATES=2, each data phase shows exactly 2 cycles of HREADYOUT=0.
3. Byte write 0xAA to 0x12 (HSIZE=0, HWSTRB=4'b0100) over 0x11223344, then read 0x10 -> 0x11AA3344. Back-to-back write then read of the same word returns the new value.
4. Read 0x1000 with MEM_DEPTH=1024 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1). Misaligned HSIZE=2 at 0x2 gives the same response. Memory is unchanged.
5. INCR4 burst NONSEQ at 0x0 then SEQ at 0x4/0x8/0xC, writing 1,2,3,4 -> readback matches. Changing HBURST on the second beat -> burst_err=1 for one cycle.
6. IDLE and BUSY transfers with HSELx=1 -> HREADYOUT=1, HRESP=0, no memory change.
